alu32_exec_stage: RTL and testbench



---
 rtl/alu32_exec_stage.sv | 165 ++++++++++++++++
 tb/tb_alu32_exec_stage.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu32_exec_stage.sv
// ---------------------------------------------------------------------------
// alu32_exec_stage
// Execute-stage ALU that consumes the 4-bit ALU control word. It accepts one
// operation per valid/ready handshake and produces a registered result with
// flags. The result sits in a one-entry output register that has its own
// valid/ready handshake toward MEM/WB. The stage can be flushed, and it keeps
// a saturating count of retired operations.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   flush              squash the held result; no acceptance this cycle
//   in_valid/in_ready  upstream handshake (in_ready is combinational)
//   in_ctr             ALU control code
//   in_a, in_b         operands
//   in_shamt           shift amount (shifts operate on in_b)
//   in_tag             destination tag, passed through
//   out_valid/out_ready downstream handshake
//   out_result         registered result
//   out_zero           out_result == 0
//   out_ovf            signed overflow (ADD/SUB only)
//   out_illegal        the control code was unassigned
//   out_tag            registered tag
//   op_count           retired operations, saturating
// ---------------------------------------------------------------------------
module alu32_exec_stage #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_ctr,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [4:0]        in_shamt,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic              out_ovf,
    output logic              out_illegal,
    output logic [TAG_W-1:0]  out_tag,
    output logic [CNT_W-1:0]  op_count
);

    localparam int MSB = DATA_W - 1;

    localparam logic [3:0] CTR_ADD  = 4'b0000;
    localparam logic [3:0] CTR_SUB  = 4'b0001;
    localparam logic [3:0] CTR_AND  = 4'b0010;
    localparam logic [3:0] CTR_SLT  = 4'b0011;
    localparam logic [3:0] CTR_XOR  = 4'b0100;
    localparam logic [3:0] CTR_SLL  = 4'b0101;
    localparam logic [3:0] CTR_OR   = 4'b0110;
    localparam logic [3:0] CTR_SRA  = 4'b0111;
    localparam logic [3:0] CTR_SLTU = 4'b1011;
    localparam logic [3:0] CTR_SRL  = 4'b1101;
    localparam logic [3:0] CTR_LUI  = 4'b1111;

    logic              valid_q,   valid_d;
    logic [DATA_W-1:0] result_q,  result_d;
    logic              zero_q,    zero_d;
    logic              ovf_q,     ovf_d;
    logic              illegal_q, illegal_d;
    logic [TAG_W-1:0]  tag_q,     tag_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    logic [DATA_W-1:0] sum_c, diff_c, res_c;
    logic              ovf_c, ill_c;
    logic              accept, retire;

    // ALU datapath
    always_comb begin
        sum_c  = in_a + in_b;   // carry-out intentionally dropped
        diff_c = in_a - in_b;
        res_c  = '0;
        ovf_c  = 1'b0;
        ill_c  = 1'b0;
        case (in_ctr)
            CTR_ADD: begin
                res_c = sum_c;
                ovf_c = (in_a[MSB] == in_b[MSB]) && (sum_c[MSB] != in_a[MSB]);
            end
            CTR_SUB: begin
                res_c = diff_c;
                ovf_c = (in_a[MSB] != in_b[MSB]) && (diff_c[MSB] != in_a[MSB]);
            end
            CTR_AND:  res_c = in_a & in_b;
            CTR_OR:   res_c = in_a | in_b;
            CTR_XOR:  res_c = in_a ^ in_b;
            CTR_SLT:  res_c = {{(DATA_W-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            CTR_SLTU: res_c = {{(DATA_W-1){1'b0}}, (in_a < in_b)};
            CTR_SLL:  res_c = in_b << in_shamt;
            CTR_SRL:  res_c = in_b >> in_shamt;
            CTR_SRA:  res_c = $unsigned($signed(in_b) >>> in_shamt);
            CTR_LUI:  res_c = in_b << 16;
            default:  ill_c = 1'b1;   // result stays 0; the op still retires
        endcase
    end

    // Handshake and output-register update
    always_comb begin
        in_ready  = !flush && (!valid_q || out_ready);
        accept    = in_valid && in_ready;
        retire    = valid_q && out_ready;

        valid_d   = valid_q;
        result_d  = result_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        illegal_d = illegal_q;
        tag_d     = tag_q;
        cnt_d     = cnt_q;

        if (flush) begin
            // squashed entry: data fields are left stale
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d   = 1'b1;
            result_d  = res_c;
            zero_d    = (res_c == '0);
            ovf_d     = ovf_c;
            illegal_d = ill_c;
            tag_d     = in_tag;
        end else if (retire) begin
            valid_d = 1'b0;
        end

        if (retire && !flush && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
            tag_q     <= '0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            illegal_q <= illegal_d;
            tag_q     <= tag_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_result  = result_q;
    assign out_zero    = zero_q;
    assign out_ovf     = ovf_q;
    assign out_illegal = illegal_q;
    assign out_tag     = tag_q;
    assign op_count    = cnt_q;

endmodule

// File: tb/tb_alu32_exec_stage.sv
module tb_alu32_exec_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_ctr = 4'h0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [4:0]  in_shamt = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_ovf;
    logic        out_illegal;
    logic [4:0]  out_tag;
    logic [15:0] op_count;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_cnt = '0;

    alu32_exec_stage #(.DATA_W(32), .TAG_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctr(in_ctr), .in_a(in_a), .in_b(in_b),
        .in_shamt(in_shamt), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_ovf(out_ovf),
        .out_illegal(out_illegal), .out_tag(out_tag), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [4:0] t);
        in_valid = 1'b1;
        in_ctr   = c;
        in_a     = a;
        in_b     = b;
        in_shamt = sh;
        in_tag   = t;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({out_valid, out_result, out_zero, out_ovf, out_illegal, out_tag, op_count} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b r=%h z=%b o=%b i=%b t=%h c=%h want all zero",
                     out_valid, out_result, out_zero, out_ovf, out_illegal, out_tag, op_count);
        end
        #2 rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_add_sub();
        out_ready = 1'b1;
        drive(4'b0000, 32'h7FFF_FFFF, 32'h1, 5'd0, 5'd3);
        tick();
        total++;
        if ({out_valid, out_result, out_ovf, out_zero, out_tag} !== {1'b1, 32'h8000_0000, 1'b1, 1'b0, 5'd3}) begin
            bad++;
            $display("FAIL add_ovf: got v=%b r=%h o=%b z=%b t=%0d want v=1 r=80000000 o=1 z=0 t=3",
                     out_valid, out_result, out_ovf, out_zero, out_tag);
        end
        drive(4'b0001, 32'd5, 32'd5, 5'd0, 5'd4);
        tick();
        exp_cnt = exp_cnt + 1;
        total++;
        if ({out_valid, out_result, out_ovf, out_zero, out_tag} !== {1'b1, 32'h0, 1'b0, 1'b1, 5'd4}) begin
            bad++;
            $display("FAIL sub_zero: got v=%b r=%h o=%b z=%b t=%0d want v=1 r=0 o=0 z=1 t=4",
                     out_valid, out_result, out_ovf, out_zero, out_tag);
        end
        drive(4'b0001, 32'h8000_0000, 32'h1, 5'd0, 5'd5);
        tick();
        exp_cnt = exp_cnt + 1;
        total++;
        if ({out_result, out_ovf} !== {32'h7FFF_FFFF, 1'b1}) begin
            bad++;
            $display("FAIL sub_ovf: got r=%h o=%b want r=7fffffff o=1", out_result, out_ovf);
        end
        in_valid = 1'b0;
        tick();
        exp_cnt = exp_cnt + 1;
        total++;
        if (out_valid !== 1'b0 || op_count !== exp_cnt) begin
            bad++;
            $display("FAIL add_sub_drain: got v=%b cnt=%0d want v=0 cnt=%0d", out_valid, op_count, exp_cnt);
        end
    endtask

    task automatic test_compare_shift();
        logic [3:0]  tc [10] = '{4'b0011, 4'b1011, 4'b0111, 4'b1111, 4'b0101,
                                 4'b1101, 4'b0010, 4'b0110, 4'b0100, 4'b0011};
        logic [31:0] ta [10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0,
                                 32'h0, 32'hF0F0_F0F0, 32'hF0F0_0000, 32'hFFFF_0000, 32'd1};
        logic [31:0] tb [10] = '{32'h1, 32'h1, 32'h8000_0000, 32'h0000_1234, 32'h1,
                                 32'h8000_0000, 32'hFF00_FF00, 32'h0000_0F0F, 32'h0F0F_0F0F, 32'hFFFF_FFFF};
        logic [4:0]  ts [10] = '{5'd0, 5'd0, 5'd4, 5'd0, 5'd31, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0};
        logic [31:0] te [10] = '{32'h1, 32'h0, 32'hF800_0000, 32'h1234_0000, 32'h8000_0000,
                                 32'h1, 32'hF000_F000, 32'hF0F0_0F0F, 32'hF0F0_0F0F, 32'h0};
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(tc[i], ta[i], tb[i], ts[i], 5'(i));
            tick();
            if (i > 0) exp_cnt = exp_cnt + 1;
            total++;
            if ({out_valid, out_result, out_ovf, out_illegal, out_tag} !== {1'b1, te[i], 1'b0, 1'b0, 5'(i)}) begin
                bad++;
                $display("FAIL op_vec%0d ctr=%b: got v=%b r=%h o=%b i=%b t=%0d want r=%h",
                         i, tc[i], out_valid, out_result, out_ovf, out_illegal, out_tag, te[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        exp_cnt = exp_cnt + 1;
        total++;
        if (op_count !== exp_cnt) begin
            bad++;
            $display("FAIL vec_count: got %0d want %0d", op_count, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(4'b0000, 32'd1, 32'd2, 5'd0, 5'd5);
        tick();
        drive(4'b0001, 32'd10, 32'd3, 5'd0, 5'd6);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if ({out_valid, out_result, out_tag, in_ready, op_count} !== {1'b1, 32'd3, 5'd5, 1'b0, exp_cnt}) begin
                bad++;
                $display("FAIL hold%0d: got v=%b r=%h t=%0d rdy=%b cnt=%0d want v=1 r=3 t=5 rdy=0 cnt=%0d",
                         i, out_valid, out_result, out_tag, in_ready, op_count, exp_cnt);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL release_ready: got %b want 1", in_ready);
        end
        tick();
        exp_cnt = exp_cnt + 1;
        total++;
        if ({out_valid, out_result, out_tag, op_count} !== {1'b1, 32'd7, 5'd6, exp_cnt}) begin
            bad++;
            $display("FAIL replace: got v=%b r=%h t=%0d cnt=%0d want v=1 r=7 t=6 cnt=%0d",
                     out_valid, out_result, out_tag, op_count, exp_cnt);
        end
        in_valid = 1'b0;
        tick();
        exp_cnt = exp_cnt + 1;
        total++;
        if (out_valid !== 1'b0 || op_count !== exp_cnt) begin
            bad++;
            $display("FAIL b2b_drain: got v=%b cnt=%0d want v=0 cnt=%0d", out_valid, op_count, exp_cnt);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(4'b0100, 32'hF0, 32'h0F, 5'd0, 5'd9);
        tick();
        total++;
        if (out_valid !== 1'b1 || out_result !== 32'hFF) begin
            bad++;
            $display("FAIL flush_setup: got v=%b r=%h want v=1 r=ff", out_valid, out_result);
        end
        flush = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL flush_in_ready: got %b want 0", in_ready);
        end
        tick();
        total++;
        if (out_valid !== 1'b0 || op_count !== exp_cnt) begin
            bad++;
            $display("FAIL flush_squash: got v=%b cnt=%0d want v=0 cnt=%0d", out_valid, op_count, exp_cnt);
        end
        // flush with downstream ready: still no retire counted, no accept
        flush = 1'b0;
        out_ready = 1'b1;
        tick();
        flush = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b0 || op_count !== exp_cnt) begin
            bad++;
            $display("FAIL flush_ready: got v=%b cnt=%0d want v=0 cnt=%0d", out_valid, op_count, exp_cnt);
        end
        flush = 1'b0;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_illegal();
        logic [3:0] codes [5] = '{4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1110};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(codes[i], 32'd7, 32'd9, 5'd2, 5'd17);
            tick();
            if (i > 0) exp_cnt = exp_cnt + 1;
            total++;
            if ({out_valid, out_result, out_illegal, out_zero, out_ovf} !== {1'b1, 32'h0, 1'b1, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL illegal_%b: got v=%b r=%h i=%b z=%b o=%b want v=1 r=0 i=1 z=1 o=0",
                         codes[i], out_valid, out_result, out_illegal, out_zero, out_ovf);
            end
        end
        in_valid = 1'b0;
        tick();
        exp_cnt = exp_cnt + 1;
        total++;
        if (op_count !== exp_cnt) begin
            bad++;
            $display("FAIL illegal_count: got %0d want %0d", op_count, exp_cnt);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(4'b0000, 32'd4, 32'd4, 5'd0, 5'd1);
        tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        exp_cnt = '0;
        total++;
        if (out_valid !== 1'b0 || op_count !== 16'h0 || out_result !== 32'h0 || out_tag !== 5'd0) begin
            bad++;
            $display("FAIL reset_mid: got v=%b cnt=%0d r=%h t=%0d want all zero",
                     out_valid, op_count, out_result, out_tag);
        end
        #1 rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        drive(4'b0000, 32'd1, 32'd1, 5'd0, 5'd2);
        // 65535 back-to-back accepts -> 65534 retires so far
        repeat (65535) tick();
        total++;
        if (op_count !== 16'hFFFE) begin
            bad++;
            $display("FAIL sat_pre: got %h want fffe", op_count);
        end
        repeat (3) tick();
        in_valid = 1'b0;
        tick();
        // 65538 retires total
        total++;
        if (op_count !== 16'hFFFF || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL sat_hold: got cnt=%h v=%b want cnt=ffff v=0", op_count, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_compare_shift();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
